pll_phase_sequencer: RTL and testbench

- Sequences the altpll dynamic phase-shift and clock-switch ports from the serial command processor's PLL settings (updatepll pulse, pll_clk_src, pll_clk_phase).
- Tracks the current phase.
- Walks to each requested phase one step at a time using the shortest direction, with the phasestep/phasedone handshake.
- Reports busy and error to the command processor.

---
 rtl/pll_phase_sequencer.sv | 234 +++++++++++++++++++++++
 tb/tb_pll_phase_sequencer.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_phase_sequencer.sv
`timescale 1ns/1ps
// pll_phase_sequencer
//   Drives the altpll dynamic phase-shift and clock-switch ports from the
//   command processor's PLL settings. A request (updatepll pulse) optionally
//   switches the input clock, then walks the PLL phase one step at a time in
//   the shortest direction using the phasestep/phasedone handshake.
//
// Ports
//   clk, rstn          system clock, asynchronous active-low reset
//   updatepll          one-clk request pulse; latches pll_clk_src/pll_clk_phase
//   pll_clk_src        requested input clock (0 = inclk0, 1 = inclk1)
//   pll_clk_phase      requested phase in steps (legal 0..PHASE_STEPS-1)
//   phasedone          altpll handshake, async, low while a step is in progress
//   activeclock        altpll currently selected input clock, async
//   phasecounterselect altpll counter select (constant COUNTER_SEL)
//   phaseupdown        altpll step direction, 1 = up
//   phasestep          altpll step strobe
//   scanclk            free-running altpll scan clock
//   clkswitch          altpll input clock switch strobe
//   current_phase      phase believed to be applied in the PLL
//   busy               FSM not idle or a request is pending
//   error              sticky; cleared when the next request is accepted
//   state_dbg          current FSM state (debug)
//
// Handshake: phasestep rises on a scanclk fall with phaseupdown valid in the
// same cycle, stays high for two scanclk rising edges and drops on the next
// scanclk fall; the PLL then signals completion by phasedone going low and
// returning high. Each phase of that wait is bounded by TIMEOUT scanclk periods.
module pll_phase_sequencer #(
  parameter int         SCANCLK_DIV   = 4,
  parameter int         PHASE_STEPS   = 64,
  parameter logic [2:0] COUNTER_SEL   = 3'b000,
  parameter int         SWITCH_CYCLES = 4,
  parameter int         TIMEOUT       = 1023
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       updatepll,
  input  logic       pll_clk_src,
  input  logic [7:0] pll_clk_phase,
  input  logic       phasedone,
  input  logic       activeclock,
  output logic [2:0] phasecounterselect,
  output logic       phaseupdown,
  output logic       phasestep,
  output logic       scanclk,
  output logic       clkswitch,
  output logic [7:0] current_phase,
  output logic       busy,
  output logic       error,
  output logic [3:0] state_dbg
);

  localparam int         DW   = $clog2(SCANCLK_DIV);
  localparam int         TW   = $clog2(TIMEOUT + 1);
  localparam int         SW   = $clog2(SWITCH_CYCLES + 1);
  localparam logic [7:0] PS8  = 8'(PHASE_STEPS);
  localparam logic [7:0] HALF = 8'(PHASE_STEPS / 2);
  localparam logic [7:0] PMAX = 8'(PHASE_STEPS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_SWITCH, S_SWITCH_WAIT, S_PLAN,
    S_STEP_ASSERT, S_STEP_LOW, S_STEP_HIGH
  } state_t;

  state_t state, state_next;

  // scanclk divider
  logic [DW-1:0] div_cnt;
  logic          div_tick, scan_fall, scan_rise;

  assign div_tick  = (div_cnt == DW'(SCANCLK_DIV - 1));
  assign scan_fall = div_tick & scanclk;
  assign scan_rise = div_tick & ~scanclk;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_cnt <= '0;
      scanclk <= 1'b0;
    end else if (div_tick) begin
      div_cnt <= '0;
      scanclk <= ~scanclk;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  // Both altpll status inputs are asynchronous to clk. phasedone idles high.
  logic pd_s1, pd_s, ac_s1, ac_s;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pd_s1 <= 1'b1;
      pd_s  <= 1'b1;
      ac_s1 <= 1'b0;
      ac_s  <= 1'b0;
    end else begin
      pd_s1 <= phasedone;
      pd_s  <= pd_s1;
      ac_s1 <= activeclock;
      ac_s  <= ac_s1;
    end
  end

  logic          pend, pend_src;
  logic [7:0]    pend_phase;
  logic          target_src, dir_up;
  logic [7:0]    target_phase, remaining, diff;
  logic          bad_target;
  logic [1:0]    rise_cnt;
  logic [SW-1:0] sw_cnt;
  logic [TW-1:0] to_cnt;
  logic          to_hit;

  assign bad_target = (target_phase >= PS8);
  assign to_hit     = (to_cnt == TW'(TIMEOUT));

  // (target - current) mod PHASE_STEPS without a divider; only meaningful
  // for a legal target.
  assign diff = (target_phase >= current_phase) ? (target_phase - current_phase)
                                                : (target_phase + PS8 - current_phase);

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:        if (pend) state_next = S_CHECK;
      S_CHECK:       state_next = (target_src != ac_s) ? S_SWITCH : S_PLAN;
      S_SWITCH:      if (sw_cnt == SW'(SWITCH_CYCLES - 1)) state_next = S_SWITCH_WAIT;
      S_SWITCH_WAIT: begin
        if (ac_s == target_src) state_next = S_PLAN;
        else if (to_hit)        state_next = S_IDLE;
      end
      S_PLAN:        state_next = (bad_target || diff == 8'd0) ? S_IDLE : S_STEP_ASSERT;
      S_STEP_ASSERT: if (phasestep && scan_fall && rise_cnt == 2'd2) state_next = S_STEP_LOW;
      S_STEP_LOW: begin
        if (!pd_s)       state_next = S_STEP_HIGH;
        else if (to_hit) state_next = S_IDLE;
      end
      S_STEP_HIGH: begin
        if (pd_s)        state_next = (remaining == 8'd1) ? S_IDLE : S_STEP_ASSERT;
        else if (to_hit) state_next = S_IDLE;
      end
      default:       state_next = S_IDLE;
    endcase
  end

  // Output / control decode
  logic accept, set_bad, abort, step_done;
  always_comb begin
    busy      = (state != S_IDLE) | pend;
    state_dbg = state;
    accept    = (state == S_IDLE) & pend;
    set_bad   = (state == S_CHECK) & bad_target;
    step_done = (state == S_STEP_HIGH) & pd_s;
    abort     = to_hit & (((state == S_SWITCH_WAIT) & (ac_s != target_src)) |
                          ((state == S_STEP_LOW)    &  pd_s) |
                          ((state == S_STEP_HIGH)   & ~pd_s));
  end

  assign phasecounterselect = COUNTER_SEL;

  // Datapath
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend          <= 1'b0;
      pend_src      <= 1'b0;
      pend_phase    <= 8'd0;
      target_src    <= 1'b0;
      target_phase  <= 8'd0;
      dir_up        <= 1'b1;
      remaining     <= 8'd0;
      current_phase <= 8'd0;
      error         <= 1'b0;
      phasestep     <= 1'b0;
      phaseupdown   <= 1'b1;
      rise_cnt      <= 2'd0;
      sw_cnt        <= '0;
      to_cnt        <= '0;
      clkswitch     <= 1'b0;
    end else begin
      if (accept) begin
        pend         <= 1'b0;
        error        <= 1'b0;
        target_src   <= pend_src;
        target_phase <= pend_phase;
      end
      // A pulse in the same cycle as acceptance (or while pending) wins.
      if (updatepll) begin
        pend       <= 1'b1;
        pend_src   <= pll_clk_src;
        pend_phase <= pll_clk_phase;
      end
      if (set_bad || abort) error <= 1'b1;

      clkswitch <= (state_next == S_SWITCH);
      sw_cnt    <= (state == S_SWITCH) ? sw_cnt + SW'(1) : '0;

      // Timeout counts scanclk periods spent in the current state.
      if (state_next != state)     to_cnt <= '0;
      else if (scan_rise && !to_hit) to_cnt <= to_cnt + TW'(1);

      if (state == S_PLAN) begin
        dir_up    <= (diff <= HALF);
        remaining <= (diff <= HALF) ? diff : (PS8 - diff);
      end

      if (state == S_STEP_ASSERT) begin
        if (!phasestep) begin
          if (scan_fall) begin
            phasestep   <= 1'b1;
            phaseupdown <= dir_up;
            rise_cnt    <= 2'd0;
          end
        end else begin
          if (scan_rise) rise_cnt <= rise_cnt + 2'd1;
          if (scan_fall && rise_cnt == 2'd2) phasestep <= 1'b0;
        end
      end

      if (step_done) begin
        remaining <= remaining - 8'd1;
        if (dir_up) current_phase <= (current_phase == PMAX) ? 8'd0 : current_phase + 8'd1;
        else        current_phase <= (current_phase == 8'd0) ? PMAX : current_phase - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_pll_phase_sequencer.sv
`timescale 1ns/1ps
module tb_pll_phase_sequencer;

  localparam int PS = 64;

  // Clock / reset
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic       updatepll = 1'b0;
  logic       pll_clk_src = 1'b0;
  logic [7:0] pll_clk_phase = 8'd0;
  logic       phasedone = 1'b1;
  logic       activeclock = 1'b0;
  logic [2:0] phasecounterselect;
  logic       phaseupdown, phasestep, scanclk, clkswitch, busy, error;
  logic [7:0] current_phase;
  logic [3:0] state_dbg;

  pll_phase_sequencer dut (
    .clk(clk), .rstn(rstn), .updatepll(updatepll), .pll_clk_src(pll_clk_src),
    .pll_clk_phase(pll_clk_phase), .phasedone(phasedone), .activeclock(activeclock),
    .phasecounterselect(phasecounterselect), .phaseupdown(phaseupdown),
    .phasestep(phasestep), .scanclk(scanclk), .clkswitch(clkswitch),
    .current_phase(current_phase), .busy(busy), .error(error), .state_dbg(state_dbg)
  );

  int compared = 0;
  int mismatched = 0;
  int exp_phase = 0;

  // PLL behaviour controls
  bit pll_stuck = 1'b0;
  bit ac_follow = 1'b1;

  // PLL phase-step model: phasedone low shortly after phasestep, high again
  // about three scanclk periods after the step request.
  always begin
    @(posedge phasestep);
    if (!pll_stuck) begin
      repeat (2) @(posedge clk);
      phasedone = 1'b0;
      repeat (3) @(posedge scanclk);
      phasedone = 1'b1;
    end
  end

  // Clock-switch model: activeclock toggles 10 clk after clkswitch rises.
  always begin
    @(posedge clkswitch);
    if (ac_follow) begin
      repeat (10) @(posedge clk);
      activeclock = ~activeclock;
    end
  end

  // Bus monitor (monotonic totals only)
  int up_total = 0, down_total = 0, width_errs = 0, edge_errs = 0;
  int sw_pulses = 0, last_sw_width = 0, sw_run = 0, ps_rises = 0;
  logic prev_ps = 1'b0, prev_sc = 1'b0, prev_ud = 1'b1, prev_sw = 1'b0;

  always @(negedge clk) begin
    if (rstn) begin
      if (phasestep && !prev_ps) begin
        if (phaseupdown) up_total++;
        else             down_total++;
        ps_rises = 0;
      end
      if (phasestep && scanclk && !prev_sc) ps_rises++;
      if (!phasestep && prev_ps && ps_rises != 2) width_errs++;
      if (((phasestep != prev_ps) || (phaseupdown != prev_ud)) && !(prev_sc && !scanclk))
        edge_errs++;
      if (clkswitch) sw_run++;
      if (!clkswitch && prev_sw) begin
        sw_pulses++;
        last_sw_width = sw_run;
      end
      if (!clkswitch) sw_run = 0;
    end
    prev_ps = phasestep;
    prev_sc = scanclk;
    prev_ud = phaseupdown;
    prev_sw = clkswitch;
  end

  // Reference model: shortest walk on a ring of PS positions, ties go up.
  function automatic void ref_plan(input int cur, input int tgt,
                                   output int ups, output int downs, output int fin);
    int d;
    ups = 0; downs = 0; fin = cur;
    if (tgt < PS) begin
      d = (tgt - cur + PS) % PS;
      if (d != 0 && d <= PS / 2) ups = d;
      else if (d != 0)           downs = PS - d;
      fin = tgt;
    end
  endfunction

  // Driver tasks
  task automatic send_req(input logic src, input int ph);
    @(posedge clk); #1;
    pll_clk_src   = src;
    pll_clk_phase = 8'(ph);
    updatepll     = 1'b1;
    @(posedge clk); #1;
    updatepll     = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit hung);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin @(negedge clk); n++; end
    hung = (busy !== 1'b0);
  endtask

  task automatic wait_step(input int budget, output bit hung);
    int n = 0;
    while (phasestep !== 1'b1 && n < budget) begin @(negedge clk); n++; end
    hung = (phasestep !== 1'b1);
  endtask

  task automatic run_req(input logic src, input int ph, input int budget,
                         output int ups, output int downs, output int sws, output bit hung);
    int u0, d0, s0;
    u0 = up_total; d0 = down_total; s0 = sw_pulses;
    send_req(src, ph);
    wait_idle(budget, hung);
    @(negedge clk);
    ups = up_total - u0; downs = down_total - d0; sws = sw_pulses - s0;
  endtask

  // Tests
  task automatic test_reset;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if ({phasecounterselect, phaseupdown, phasestep, scanclk, clkswitch, busy, error} !== 9'b000_1_00000) begin
      mismatched++;
      $display("FAIL reset_ctrl: got %b want 000100000",
               {phasecounterselect, phaseupdown, phasestep, scanclk, clkswitch, busy, error});
    end
    compared++;
    if (current_phase !== 8'd0) begin
      mismatched++; $display("FAIL reset_phase: got %0d want 0", current_phase);
    end
    @(posedge clk); #1 rstn = 1'b1;
    repeat (4) @(negedge clk);
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_basic_up;
    int u0, d0, eu, ed, ef;
    bit hung;
    u0 = up_total; d0 = down_total;
    ref_plan(exp_phase, 5, eu, ed, ef);
    @(posedge clk); #1;
    pll_clk_src = 1'b0; pll_clk_phase = 8'd5; updatepll = 1'b1;
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL busy_before: got %b want 0", busy); end
    @(posedge clk); #1;
    updatepll = 1'b0;
    compared++;
    if (busy !== 1'b1) begin mismatched++; $display("FAIL busy_latency: got %b want 1", busy); end
    wait_idle(5000, hung);
    @(negedge clk);
    compared++;
    if (hung) begin mismatched++; $display("FAIL basic_done: busy stuck, want idle"); end
    compared++;
    if (up_total - u0 !== eu || down_total - d0 !== ed) begin
      mismatched++;
      $display("FAIL basic_steps: got up %0d down %0d want up %0d down %0d", up_total - u0, down_total - d0, eu, ed);
    end
    compared++;
    if (phaseupdown !== 1'b1) begin mismatched++; $display("FAIL basic_dir: got %b want 1", phaseupdown); end
    compared++;
    if (current_phase !== 8'(ef) || error !== 1'b0) begin
      mismatched++; $display("FAIL basic_end: got phase %0d err %b want %0d err 0", current_phase, error, ef);
    end
    exp_phase = ef;
  endtask

  task automatic test_wrap_and_tie;
    int ups, downs, sws, eu, ed, ef, w0, e0;
    bit hung;
    int tgts[3] = '{60, 0, 32};
    w0 = width_errs; e0 = edge_errs;
    foreach (tgts[i]) begin
      ref_plan(exp_phase, tgts[i], eu, ed, ef);
      run_req(activeclock, tgts[i], 5000, ups, downs, sws, hung);
      compared++;
      if (hung || ups !== eu || downs !== ed) begin
        mismatched++;
        $display("FAIL move_%0d: hung %b got up %0d down %0d want up %0d down %0d", tgts[i], hung, ups, downs, eu, ed);
      end
      compared++;
      if (current_phase !== 8'(ef) || error !== 1'b0) begin
        mismatched++; $display("FAIL move_%0d_end: got phase %0d err %b want %0d err 0", tgts[i], current_phase, error, ef);
      end
      exp_phase = ef;
    end
    compared++;
    if (width_errs - w0 !== 0) begin
      mismatched++; $display("FAIL step_width: got %0d bad pulses want 0", width_errs - w0);
    end
    compared++;
    if (edge_errs - e0 !== 0) begin
      mismatched++; $display("FAIL step_edge: got %0d off-fall changes want 0", edge_errs - e0);
    end
  endtask

  task automatic test_switch;
    int ups, downs, sws, eu, ed, ef, tgt;
    bit hung;
    logic src;
    src = ~activeclock;
    tgt = (exp_phase + 2) % PS;
    ref_plan(exp_phase, tgt, eu, ed, ef);
    run_req(src, tgt, 5000, ups, downs, sws, hung);
    compared++;
    if (hung || sws !== 1 || last_sw_width !== 4) begin
      mismatched++; $display("FAIL switch_pulse: hung %b got %0d pulses width %0d want 1 width 4", hung, sws, last_sw_width);
    end
    compared++;
    if (ups !== eu || downs !== ed || current_phase !== 8'(ef) || error !== 1'b0 || activeclock !== src) begin
      mismatched++;
      $display("FAIL switch_move: got up %0d down %0d phase %0d err %b want up %0d down %0d phase %0d err 0",
               ups, downs, current_phase, error, eu, ed, ef);
    end
    exp_phase = ef;
    // activeclock never follows: switch times out, no stepping
    ac_follow = 1'b0;
    run_req(~activeclock, (exp_phase + 5) % PS, 20000, ups, downs, sws, hung);
    ac_follow = 1'b1;
    compared++;
    if (hung || error !== 1'b1 || sws !== 1) begin
      mismatched++; $display("FAIL switch_stuck_err: hung %b got err %b pulses %0d want err 1 pulses 1", hung, error, sws);
    end
    compared++;
    if (ups + downs !== 0 || current_phase !== 8'(exp_phase)) begin
      mismatched++; $display("FAIL switch_stuck_steps: got %0d steps phase %0d want 0 steps phase %0d",
                             ups + downs, current_phase, exp_phase);
    end
  endtask

  task automatic test_timeout_and_illegal;
    int ups, downs, sws, eu, ed, ef;
    bit hung;
    pll_stuck = 1'b1;
    run_req(activeclock, (exp_phase + 2) % PS, 20000, ups, downs, sws, hung);
    pll_stuck = 1'b0;
    compared++;
    if (hung || error !== 1'b1 || current_phase !== 8'(exp_phase)) begin
      mismatched++; $display("FAIL step_timeout: hung %b got err %b phase %0d want err 1 phase %0d",
                             hung, error, current_phase, exp_phase);
    end
    run_req(activeclock, 70, 2000, ups, downs, sws, hung);
    compared++;
    if (hung || error !== 1'b1 || ups + downs !== 0 || current_phase !== 8'(exp_phase)) begin
      mismatched++; $display("FAIL illegal_70: hung %b got err %b steps %0d phase %0d want err 1 steps 0 phase %0d",
                             hung, error, ups + downs, current_phase, exp_phase);
    end
    ref_plan(exp_phase, 3, eu, ed, ef);
    run_req(activeclock, 3, 5000, ups, downs, sws, hung);
    compared++;
    if (hung || error !== 1'b0 || ups !== eu || downs !== ed || current_phase !== 8'(ef)) begin
      mismatched++; $display("FAIL recover_3: hung %b got err %b up %0d down %0d phase %0d want err 0 up %0d down %0d phase %0d",
                             hung, error, ups, downs, current_phase, eu, ed, ef);
    end
    exp_phase = ef;
  endtask

  task automatic test_random;
    int ups, downs, sws, eu, ed, ef, ph;
    bit hung, esw;
    logic src;
    for (int k = 0; k < 5; k++) begin
      ph  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(64, 255)) : int'($urandom_range(0, PS - 1));
      src = 1'($urandom_range(0, 1));
      esw = (src != activeclock);
      ref_plan(exp_phase, ph, eu, ed, ef);
      run_req(src, ph, 6000, ups, downs, sws, hung);
      compared++;
      if (hung || ups !== eu || downs !== ed || sws !== int'(esw)) begin
        mismatched++;
        $display("FAIL rand_%0d ph %0d: hung %b got up %0d down %0d sw %0d want up %0d down %0d sw %0d",
                 k, ph, hung, ups, downs, sws, eu, ed, esw);
      end
      compared++;
      if (current_phase !== 8'(ef) || error !== 1'(ph >= PS)) begin
        mismatched++; $display("FAIL rand_%0d_end: got phase %0d err %b want %0d err %b",
                               k, current_phase, error, ef, ph >= PS);
      end
      exp_phase = ef;
    end
  endtask

  task automatic test_back_to_back;
    int u0, d0, t1, eu, ed, ef;
    bit hung;
    u0 = up_total; d0 = down_total;
    t1 = (exp_phase + 10) % PS;
    ref_plan(t1, 7, eu, ed, ef);
    send_req(activeclock, t1);
    wait_step(2000, hung);
    send_req(activeclock, 2);
    repeat (3) @(posedge clk);
    send_req(activeclock, 7);
    wait_idle(8000, hung);
    @(negedge clk);
    compared++;
    if (hung || up_total - u0 !== 10 + eu || down_total - d0 !== ed) begin
      mismatched++; $display("FAIL b2b_steps: hung %b got up %0d down %0d want up %0d down %0d",
                             hung, up_total - u0, down_total - d0, 10 + eu, ed);
    end
    compared++;
    if (current_phase !== 8'(ef) || error !== 1'b0) begin
      mismatched++; $display("FAIL b2b_end: got phase %0d err %b want %0d err 0", current_phase, error, ef);
    end
    exp_phase = ef;
  endtask

  task automatic test_reset_mid;
    bit hung;
    send_req(activeclock, (exp_phase + 10) % PS);
    wait_step(2000, hung);
    compared++;
    if (hung) begin mismatched++; $display("FAIL mid_start: phasestep 0 want 1"); end
    @(negedge clk); #2;
    rstn = 1'b0;
    #1;
    compared++;
    if ({phasecounterselect, phaseupdown, phasestep, scanclk, clkswitch, busy, error} !== 9'b000_1_00000 ||
        current_phase !== 8'd0) begin
      mismatched++;
      $display("FAIL mid_reset: got ctrl %b phase %0d want 000100000 phase 0",
               {phasecounterselect, phaseupdown, phasestep, scanclk, clkswitch, busy, error}, current_phase);
    end
    exp_phase = 0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (20) @(negedge clk);
    compared++;
    if (busy !== 1'b0 || phasestep !== 1'b0 || current_phase !== 8'd0) begin
      mismatched++; $display("FAIL mid_after: got busy %b step %b phase %0d want 0 0 0", busy, phasestep, current_phase);
    end
  endtask

  initial begin
    test_reset();
    test_basic_up();
    test_wrap_and_tie();
    test_switch();
    test_timeout_and_illegal();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded 900us, want completion");
    $fatal(1, "watchdog");
  end

endmodule
